regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Writeback stage directly upstream of the simulation register-file model; drives its RD write port (en/addr/data).
- Arbitrates between the ALU and LSU result streams with valid/ready handshakes.
- Registers exactly one winning write per cycle and suppresses writes to x0.
- Includes a starvation guard and a committed-write counter.

Parameters:
- REG_NUM_WIDTH, 5, register index width.
- REG_WIDTH, 32, register data width.
- STARVE_LIMIT, 4, consecutive ALU-losing cycles before the ALU is force-granted; legal range 1..255.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- ioAlu_valid  in  1  ALU result valid.
- ioAlu_ready  out  1  ALU result accepted this cycle.
- ioAlu_rd  in  REG_NUM_WIDTH  ALU destination register.
- ioAlu_data  in  REG_WIDTH  ALU result.
- ioLsu_valid  in  1  LSU result valid.
- ioLsu_ready  out  1  LSU result accepted this cycle.
- ioLsu_rd  in  REG_NUM_WIDTH  LSU destination register.
- ioLsu_data  in  REG_WIDTH  LSU load data.
- ioRegFile_ioRD_en  out  1  register-file write enable.
- ioRegFile_ioRD_addr  out  REG_NUM_WIDTH  write address.
- ioRegFile_ioRD_data  out  REG_WIDTH  write data.
- ioStat_wbCount  out  32  committed-write count.

Behaviour:
- Clock and reset: one clock, `clock`; reset is asynchronous and active-high, port `reset`.
- Reset values: RD_en, RD_addr, RD_data, wbCount and the starvation counter are all 0; both ready outputs are 0 while reset is asserted.
- Reset mid-operation: outputs clear immediately without waiting for a clock edge. Any not-yet-registered transfer is dropped; sources keep it pending because ready was 0.
- Handshake:
  - A transfer completes when valid && ready.
  - Sources hold valid, rd and data stable until accepted.
  - Ready is combinational from both valids and the starvation state. At most one ready is high per cycle.
  - The register file never back-pressures, so a grant is always issued when any source is valid.
- Arbitration:
  - LSU wins by default.
  - starve_cnt (width $clog2(STARVE_LIMIT+1)) increments when ALU is valid and LSU is granted.
  - starve_cnt clears when ALU is granted or ALU is not valid.
  - When starve_cnt == STARVE_LIMIT and ALU is valid, ALU is granted regardless of LSU.
- Single valid: only one source valid -> that source is granted in the same cycle.
- Latency: exactly one cycle. Data accepted in cycle N appears on ioRegFile_ioRD_* in cycle N+1, with RD_en high for one cycle per accepted non-zero rd.
- x0 writes: the transfer is accepted (ready=1), RD_en stays 0 the next cycle, RD_addr/RD_data hold their previous values, and wbCount does not increment.
- Idle (no grant): RD_en=0 next cycle; addr/data hold.
- wbCount: increments by 1 on every cycle RD_en is 1; wraps from 0xFFFF_FFFF to 0.
- Back-to-back: a new write can be accepted every cycle; consecutive writes to the same rd are committed in grant order.

Optional Feature:
- Macro: WB_BYPASS_EN.
- With the macro defined, add ports:
  - ioByp_rs1_addr  in  REG_NUM_WIDTH
  - ioByp_rs2_addr  in  REG_NUM_WIDTH
  - ioByp_rs1_hit  out  1
  - ioByp_rs1_data  out  REG_WIDTH
  - ioByp_rs2_hit  out  1
  - ioByp_rs2_data  out  REG_WIDTH
- Bypass rule: rsX_hit = RD_en && RD_addr == rsX_addr && rsX_addr != 0; rsX_data = RD_data when hit, else 0. Purely combinational from the registered outputs; 0 during reset.
- Without the macro: the ports and logic are absent; the block is otherwise identical.

Decomposition:
- Package wb_pkg:
  - WB_SRC_ALU and WB_SRC_LSU enum (grant select).
  - wb_req_t struct {valid, rd, data}.
  - WB_ZERO_REG constant (0).
- One sub-module, wb_starve_arb: grant logic plus starve_cnt. Outputs grant_alu and grant_lsu.
- The top level holds the output registers, x0 suppression, wbCount and the optional bypass.

Test Plan:
- Reset release, no traffic for 10 cycles -> RD_en=0, RD_addr=0, RD_data=0, wbCount=0 throughout.
- ALU only: rd=5, data=0xDEADBEEF in cycle 3 -> ioAlu_ready=1 in cycle 3; cycle 4 RD_en=1, addr=5, data=0xDEADBEEF; wbCount=1.
- Both valid continuously, STARVE_LIMIT=4, LSU rd=1..n, ALU rd=9 -> four LSU commits, then ALU rd=9 committed in the 5th slot, then LSU resumes; starve_cnt returns to 0.
- LSU rd=0, data=0x1234 -> ioLsu_ready=1; next cycle RD_en=0, addr/data unchanged, wbCount unchanged.
- Reset asserted asynchronously mid-stream between edges while RD_en=1 -> RD_en, addr, data, wbCount go to 0 before the next edge; after release, the held ALU request (rd=7) commits one cycle after its grant.
- WB_BYPASS_EN: commit rd=3, data=0x55; rs1_addr=3, rs2_addr=0 -> rs1_hit=1, rs1_data=0x55, rs2_hit=0, rs2_data=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Pure declarations: no latency or backpressure of its own.
// Imported by regfile_wb_arbiter, wb_starve_arb and their bench.
package wb_pkg;

  // Default widths of the register index and register data.
  localparam int WB_REG_NUM_WIDTH = 5;
  localparam int WB_REG_WIDTH     = 32;

  // Architectural zero register: writes to it are accepted but never committed.
  localparam int WB_ZERO_REG = 0;

  // Which result stream owns the write port this cycle.
  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  // One result-stream request at the default widths.
  typedef struct packed {
    logic                        valid;
    logic [WB_REG_NUM_WIDTH-1:0] rd;
    logic [WB_REG_WIDTH-1:0]     data;
  } wb_req_t;

  // Committed-write counter step; wraps naturally at 2^32.
  function automatic logic [31:0] wb_count_next(input logic [31:0] cnt, input logic en);
    return cnt + {31'b0, en};
  endfunction

endpackage

// File: rtl/wb_starve_arb.sv
// Grant logic for ALU vs LSU writeback: LSU-priority with an ALU starvation guard.
// Latency: grants are combinational from the valids; only the starvation count is registered.
// Backpressure: exactly one grant when any source is valid; no grants while reset is high.
module wb_starve_arb
  import wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic alu_valid_i,
  input  logic lsu_valid_i,
  output logic grant_alu_o,
  output logic grant_lsu_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             force_alu;

  // ALU has lost STARVE_LIMIT cycles in a row: it takes the port this cycle.
  always_comb begin
    force_alu = alu_valid_i && (starve_cnt_q == LIMIT_C);
  end

  // LSU wins by default; ALU wins when alone or when forced. Nothing is granted in reset.
  always_comb begin
    grant_alu_o = 1'b0;
    grant_lsu_o = 1'b0;
    if (!reset) begin
      grant_alu_o = alu_valid_i && (force_alu || !lsu_valid_i);
      grant_lsu_o = lsu_valid_i && !force_alu;
    end
  end

  // Count consecutive cycles where the ALU waits behind the LSU; any ALU win or idle ALU clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!alu_valid_i || grant_alu_o) begin
      starve_cnt_d = '0;
    end else if (grant_lsu_o) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback stage: arbitrates ALU/LSU results onto the register-file RD port; WB_BYPASS_EN adds rs1/rs2 forwarding.
// Latency: one cycle from accepted handshake to RD_en/addr/data; x0 writes are accepted but not committed.
// Backpressure: ready is combinational and one-hot; the register file never stalls, so any valid source is served.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int REG_NUM_WIDTH = WB_REG_NUM_WIDTH,
  parameter int REG_WIDTH     = WB_REG_WIDTH,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ioAlu_valid,
  output logic                     ioAlu_ready,
  input  logic [REG_NUM_WIDTH-1:0] ioAlu_rd,
  input  logic [REG_WIDTH-1:0]     ioAlu_data,
  input  logic                     ioLsu_valid,
  output logic                     ioLsu_ready,
  input  logic [REG_NUM_WIDTH-1:0] ioLsu_rd,
  input  logic [REG_WIDTH-1:0]     ioLsu_data,
  output logic                     ioRegFile_ioRD_en,
  output logic [REG_NUM_WIDTH-1:0] ioRegFile_ioRD_addr,
  output logic [REG_WIDTH-1:0]     ioRegFile_ioRD_data,
  output logic [31:0]              ioStat_wbCount
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_NUM_WIDTH-1:0] ioByp_rs1_addr,
  input  logic [REG_NUM_WIDTH-1:0] ioByp_rs2_addr,
  output logic                     ioByp_rs1_hit,
  output logic [REG_WIDTH-1:0]     ioByp_rs1_data,
  output logic                     ioByp_rs2_hit,
  output logic [REG_WIDTH-1:0]     ioByp_rs2_data
`endif
);

  localparam logic [REG_NUM_WIDTH-1:0] ZERO_RD = REG_NUM_WIDTH'(WB_ZERO_REG);

  logic                     grant_alu;
  logic                     grant_lsu;
  wb_src_e                  win_src;
  logic                     win_take;
  logic [REG_NUM_WIDTH-1:0] win_rd;
  logic [REG_WIDTH-1:0]     win_data;

  logic                     rd_en_q,   rd_en_d;
  logic [REG_NUM_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [REG_WIDTH-1:0]     rd_data_q, rd_data_d;
  logic [31:0]              wb_cnt_q,  wb_cnt_d;

  wb_starve_arb #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clock       (clock),
    .reset       (reset),
    .alu_valid_i (ioAlu_valid),
    .lsu_valid_i (ioLsu_valid),
    .grant_alu_o (grant_alu),
    .grant_lsu_o (grant_lsu)
  );

  // Ready is the grant itself: a source is accepted the same cycle it wins.
  always_comb begin
    ioAlu_ready = grant_alu;
    ioLsu_ready = grant_lsu;
  end

  // Select the winning request's destination and data.
  always_comb begin
    win_take = grant_alu || grant_lsu;
    win_src  = grant_alu ? WB_SRC_ALU : WB_SRC_LSU;
    win_rd   = (win_src == WB_SRC_ALU) ? ioAlu_rd   : ioLsu_rd;
    win_data = (win_src == WB_SRC_ALU) ? ioAlu_data : ioLsu_data;
  end

  // Commit only non-x0 winners; on idle or x0 the address/data registers hold their last commit.
  always_comb begin
    rd_en_d   = win_take && (win_rd != ZERO_RD);
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (rd_en_d) begin
      rd_addr_d = win_rd;
      rd_data_d = win_data;
    end
    // The count moves with RD_en so it already includes the write currently on the port.
    wb_cnt_d = wb_count_next(wb_cnt_q, rd_en_d);
  end

  // Output and statistics registers; reset clears them immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      wb_cnt_q  <= '0;
    end else begin
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      wb_cnt_q  <= wb_cnt_d;
    end
  end

  // Drive the register-file port and statistics straight from the registers.
  always_comb begin
    ioRegFile_ioRD_en   = rd_en_q;
    ioRegFile_ioRD_addr = rd_addr_q;
    ioRegFile_ioRD_data = rd_data_q;
    ioStat_wbCount      = wb_cnt_q;
  end

`ifdef WB_BYPASS_EN
  // Forward the write on the port to same-cycle readers; x0 never hits.
  always_comb begin
    ioByp_rs1_hit  = rd_en_q && (rd_addr_q == ioByp_rs1_addr) && (ioByp_rs1_addr != ZERO_RD);
    ioByp_rs2_hit  = rd_en_q && (rd_addr_q == ioByp_rs2_addr) && (ioByp_rs2_addr != ZERO_RD);
    ioByp_rs1_data = ioByp_rs1_hit ? rd_data_q : '0;
    ioByp_rs2_data = ioByp_rs2_hit ? rd_data_q : '0;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: table-driven single-cycle vectors plus starvation, async reset and bypass sequences.
// Inputs change on the falling edge; readies are sampled 1ns later and RD outputs at the next falling edge.
// Sources hold a losing request until it is accepted.
module tb_regfile_wb_arbiter;
  import wb_pkg::*;

  logic        clock;
  logic        reset;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd;
  logic [31:0] alu_data, lsu_data;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] wb_count;
`ifdef WB_BYPASS_EN
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_hit, rs2_hit;
  logic [31:0] rs1_data, rs2_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_arbiter #(
    .REG_NUM_WIDTH (5),
    .REG_WIDTH     (32),
    .STARVE_LIMIT  (4)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .ioAlu_valid         (alu_valid),
    .ioAlu_ready         (alu_ready),
    .ioAlu_rd            (alu_rd),
    .ioAlu_data          (alu_data),
    .ioLsu_valid         (lsu_valid),
    .ioLsu_ready         (lsu_ready),
    .ioLsu_rd            (lsu_rd),
    .ioLsu_data          (lsu_data),
    .ioRegFile_ioRD_en   (rd_en),
    .ioRegFile_ioRD_addr (rd_addr),
    .ioRegFile_ioRD_data (rd_data),
    .ioStat_wbCount      (wb_count)
`ifdef WB_BYPASS_EN
    ,
    .ioByp_rs1_addr      (rs1_addr),
    .ioByp_rs2_addr      (rs2_addr),
    .ioByp_rs1_hit       (rs1_hit),
    .ioByp_rs1_data      (rs1_data),
    .ioByp_rs2_hit       (rs2_hit),
    .ioByp_rs2_data      (rs2_data)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    wb_req_t     alu;
    wb_req_t     lsu;
    logic        exp_alu_rdy;
    logic        exp_lsu_rdy;
    logic        exp_en;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [31:0] exp_cnt;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                              input logic ear, input logic elr, input logic een,
                              input logic [4:0] ea, input logic [31:0] ed, input logic [31:0] ec);
    vec_t v;
    v.alu = '{valid: av, rd: ard, data: ad};
    v.lsu = '{valid: lv, rd: lrd, data: ld};
    v.exp_alu_rdy = ear;
    v.exp_lsu_rdy = elr;
    v.exp_en      = een;
    v.exp_addr    = ea;
    v.exp_data    = ed;
    v.exp_cnt     = ec;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic en, input logic [4:0] a,
                            input logic [31:0] d, input logic [31:0] c);
    check({tag, " rd_en"},   {31'b0, rd_en}, {31'b0, en});
    check({tag, " rd_addr"}, {27'b0, rd_addr}, {27'b0, a});
    check({tag, " rd_data"}, rd_data, d);
    check({tag, " wbCount"}, wb_count, c);
  endtask

  task automatic check_rdy(input string tag, input logic ar, input logic lr);
    check({tag, " alu_ready"}, {31'b0, alu_ready}, {31'b0, ar});
    check({tag, " lsu_ready"}, {31'b0, lsu_ready}, {31'b0, lr});
  endtask

  vec_t tbl [10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_wb;
    int lsu_k, alu_k;
    logic exp_alu;

    // Register file state after each vector, starting from reset (addr 0, data 0, count 0).
    tbl[0] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 5'd0,  32'h0,        32'd0);
    tbl[1] = mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,        1, 0, 1, 5'd5,  32'hDEADBEEF, 32'd1);
    tbl[2] = mk(0, 5'd0,  32'h0,        1, 5'd10, 32'hCAFE0001, 0, 1, 1, 5'd10, 32'hCAFE0001, 32'd2);
    tbl[3] = mk(0, 5'd0,  32'h0,        1, 5'd0,  32'h00001234, 0, 1, 0, 5'd10, 32'hCAFE0001, 32'd2);
    tbl[4] = mk(1, 5'd0,  32'h77,       0, 5'd0,  32'h0,        1, 0, 0, 5'd10, 32'hCAFE0001, 32'd2);
    tbl[5] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 5'd10, 32'hCAFE0001, 32'd2);
    tbl[6] = mk(1, 5'd31, 32'hFFFFFFFF, 0, 5'd0,  32'h0,        1, 0, 1, 5'd31, 32'hFFFFFFFF, 32'd3);
    tbl[7] = mk(0, 5'd0,  32'h0,        1, 5'd31, 32'h0,        0, 1, 1, 5'd31, 32'h0,        32'd4);
    tbl[8] = mk(1, 5'd2,  32'h22,       1, 5'd3,  32'h33,       0, 1, 1, 5'd3,  32'h33,       32'd5);
    tbl[9] = mk(1, 5'd2,  32'h22,       0, 5'd0,  32'h0,        1, 0, 1, 5'd2,  32'h22,       32'd6);

    // Reset asserted with both sources valid: nothing may be granted.
    reset = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h2;
`ifdef WB_BYPASS_EN
    rs1_addr = 5'd0; rs2_addr = 5'd0;
`endif
    #3;
    check_rdy("in_reset", 0, 0);
    check_outs("in_reset", 0, 5'd0, 32'h0, 32'd0);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // Ten idle cycles after release.
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_outs("idle", 0, 5'd0, 32'h0, 32'd0);
    end

    // Table vectors.
    for (int i = 0; i < 10; i++) begin
      alu_valid = tbl[i].alu.valid; alu_rd = tbl[i].alu.rd; alu_data = tbl[i].alu.data;
      lsu_valid = tbl[i].lsu.valid; lsu_rd = tbl[i].lsu.rd; lsu_data = tbl[i].lsu.data;
      #1;
      check_rdy($sformatf("vec%0d", i), tbl[i].exp_alu_rdy, tbl[i].exp_lsu_rdy);
      @(negedge clock);
      check_outs($sformatf("vec%0d", i), tbl[i].exp_en, tbl[i].exp_addr, tbl[i].exp_data, tbl[i].exp_cnt);
    end

    // Both valid continuously: winner pattern L L L L A, repeated twice.
    exp_wb = tbl[9].exp_cnt;
    lsu_k = 1;
    alu_k = 0;
    for (int i = 0; i < 10; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd9;          alu_data = 32'h900 + alu_k;
      lsu_valid = 1'b1; lsu_rd = 5'(lsu_k);     lsu_data = 32'h100 + lsu_k;
      exp_alu = ((i % 5) == 4);
      #1;
      check_rdy($sformatf("starve%0d", i), exp_alu, !exp_alu);
      @(negedge clock);
      exp_wb = exp_wb + 1;
      if (exp_alu) begin
        check_outs($sformatf("starve%0d", i), 1, 5'd9, 32'h900 + alu_k, exp_wb);
        alu_k++;
      end else begin
        check_outs($sformatf("starve%0d", i), 1, 5'(lsu_k), 32'h100 + lsu_k, exp_wb);
        lsu_k++;
      end
    end

    // Async reset between edges while a write is on the port; the losing ALU request survives it.
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
    #1;
    check_rdy("pre_rst", 0, 1);
    @(posedge clock);
    #1;
    check_outs("pre_rst", 1, 5'd4, 32'h44, exp_wb + 1);
    #1;
    reset = 1'b1;
    #1;
    check_outs("async_rst", 0, 5'd0, 32'h0, 32'd0);
    check_rdy("async_rst", 0, 0);
    lsu_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_rdy("post_rst", 1, 0);
    @(negedge clock);
    check_outs("post_rst", 1, 5'd7, 32'h7777, 32'd1);
    alu_valid = 1'b0;
    @(negedge clock);
    check_outs("post_rst_idle", 0, 5'd7, 32'h7777, 32'd1);

`ifdef WB_BYPASS_EN
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h55;
    @(negedge clock);
    alu_valid = 1'b0;
    rs1_addr = 5'd3; rs2_addr = 5'd0;
    #1;
    check("byp rs1_hit",  {31'b0, rs1_hit}, 32'd1);
    check("byp rs1_data", rs1_data, 32'h55);
    check("byp rs2_hit",  {31'b0, rs2_hit}, 32'd0);
    check("byp rs2_data", rs2_data, 32'h0);
    @(negedge clock);
    #1;
    check("byp idle rs1_hit",  {31'b0, rs1_hit}, 32'd0);
    check("byp idle rs1_data", rs1_data, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
